// File: rtl/key_pkg.sv
// Shared definitions for the 4-key panel front end: FSM state encoding,
// the idle key pattern and the key-code <-> active-low one-hot helpers.
package key_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS  = 3'd1;
    localparam logic [2:0] ST_HELD   = 3'd2;
    localparam logic [2:0] ST_REPEAT = 3'd3;
    localparam logic [2:0] ST_LOCK   = 3'd4;

    localparam logic [3:0] KEY_NONE = 4'b1111;

    // Code-to-pattern table used by the display side.
    function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
        logic [3:0] oh;
        case (code)
            2'd3:    oh = 4'b0111;
            2'd2:    oh = 4'b1011;
            2'd1:    oh = 4'b1101;
            default: oh = 4'b1110;
        endcase
        return oh;
    endfunction

    // Only meaningful when exactly one bit is low.
    function automatic logic [1:0] onehot_to_code(input logic [3:0] k);
        logic [1:0] code;
        case (k)
            4'b0111: code = 2'd3;
            4'b1011: code = 2'd2;
            4'b1101: code = 2'd1;
            default: code = 2'd0;
        endcase
        return code;
    endfunction

    // Number of pressed (low) keys.
    function automatic logic [2:0] low_count(input logic [3:0] k);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~k[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus shared-counter debouncer for four active-low keys.
// Ports: clk, rst_n, key_raw[3:0] (async raw keys), key_deb[3:0] (debounced).
module key_debounce
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_raw,
    output logic [3:0] key_deb
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_TC = CW'(DEB_CYCLES - 1);

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    samp_q, samp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    deb_q, deb_d;

    // The whole vector shares one counter: any change on any key restarts
    // the stability window, so key_deb only ever moves to a vector that
    // was seen unchanged for DEB_CYCLES clocks.
    always_comb begin
        samp_d = samp_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (sync2_q != samp_q) begin
            samp_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != DEB_TC) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            deb_d = samp_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= KEY_NONE;
            sync2_q <= KEY_NONE;
            samp_q  <= KEY_NONE;
            cnt_q   <= '0;
            deb_q   <= KEY_NONE;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    assign key_deb = deb_q;

endmodule

// File: rtl/key_scan_encoder.sv
// 4-key panel front end: debounce, single-press encode, auto-repeat, lockout.
// Ports: clk, rst_n, key[3:0] in; key_deb, key_code, key_onehot, key_valid,
// key_repeat, key_multi out (key patterns active-low).
module key_scan_encoder
    import key_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000,
    parameter int REP_DLY    = 25000000,
    parameter int REP_PER    = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key,
    output logic [3:0] key_deb,
    output logic [1:0] key_code,
    output logic [3:0] key_onehot,
    output logic       key_valid,
    output logic       key_repeat,
    output logic       key_multi
);

    localparam int MAX_A = (DEB_CYCLES > REP_DLY) ? DEB_CYCLES : REP_DLY;
    localparam int MAXP  = (MAX_A > REP_PER) ? MAX_A : REP_PER;
    localparam int RW    = $clog2(MAXP + 1);
    localparam bit REP_EN = (REP_DLY != 0);
    localparam logic [RW-1:0] DLY_TC  = RW'((REP_DLY > 0) ? REP_DLY - 1 : 0);
    localparam logic [RW-1:0] PER_TC  = RW'((REP_PER > 0) ? REP_PER - 1 : 0);
    localparam logic [RW-1:0] CNT_MAX = RW'(MAXP);

    logic [3:0]    deb;
    logic [2:0]    low_n;
    logic [RW-1:0] tc;

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [1:0]    code_q, code_d;
    logic [3:0]    oh_q, oh_d;
    logic          valid_q, valid_d;
    logic          rpt_q, rpt_d;
    logic          multi_q, multi_d;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_raw(key),
        .key_deb(deb)
    );

    assign low_n = low_count(deb);
    assign tc    = (state_q == ST_HELD) ? DLY_TC : PER_TC;

    // key_valid is registered on the transition into PRESS, so the PRESS
    // cycle is the strobe cycle. The counter is cleared on entry to PRESS
    // and PRESS already counts as the first held cycle, which puts the
    // first repeat REP_DLY clocks after the press strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        oh_d    = oh_q;
        valid_d = 1'b0;
        rpt_d   = 1'b0;
        multi_d = (low_n >= 3'd2);
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (low_n == 3'd1) begin
                    state_d = ST_PRESS;
                    valid_d = 1'b1;
                    code_d  = onehot_to_code(deb);
                    oh_d    = code_to_onehot(onehot_to_code(deb));
                end else if (low_n >= 3'd2) begin
                    state_d = ST_LOCK;
                end
            end
            ST_PRESS: begin
                cnt_d   = RW'(1);
                state_d = ST_HELD;
            end
            ST_HELD, ST_REPEAT: begin
                if (deb == KEY_NONE) begin
                    state_d = ST_IDLE;
                end else if (deb != oh_q) begin
                    state_d = ST_LOCK;
                end else if (REP_EN && (cnt_q >= tc)) begin
                    state_d = ST_REPEAT;
                    valid_d = 1'b1;
                    rpt_d   = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOCK: begin
                if (deb == KEY_NONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= 2'd0;
            oh_q    <= KEY_NONE;
            valid_q <= 1'b0;
            rpt_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            oh_q    <= oh_d;
            valid_q <= valid_d;
            rpt_q   <= rpt_d;
            multi_q <= multi_d;
        end
    end

    assign key_deb    = deb;
    assign key_code   = code_q;
    assign key_onehot = oh_q;
    assign key_valid  = valid_q;
    assign key_repeat = rpt_q;
    assign key_multi  = multi_q;

endmodule

// File: tb/tb_key_scan_encoder.sv
// Directed self-checking bench for key_scan_encoder (DEB=4, REP_DLY=20, REP_PER=8).
module tb_key_scan_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] key_deb;
    logic [1:0] key_code;
    logic [3:0] key_onehot;
    logic       key_valid;
    logic       key_repeat;
    logic       key_multi;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         t;
        logic [1:0] code;
        logic       rpt;
    } ev_t;

    typedef struct {
        logic [3:0] k;
        logic [1:0] code;
        logic [3:0] oh;
    } vec_t;

    ev_t  evq[$];
    ev_t  expq[$];
    vec_t vt[4];

    key_scan_encoder #(
        .DEB_CYCLES(4),
        .REP_DLY   (20),
        .REP_PER   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .key_deb   (key_deb),
        .key_code  (key_code),
        .key_onehot(key_onehot),
        .key_valid (key_valid),
        .key_repeat(key_repeat),
        .key_multi (key_multi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            ev_t e;
            e.t    = cyc;
            e.code = key_code;
            e.rpt  = key_repeat;
            evq.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic drive(input logic [3:0] k);
        @(posedge clk);
        #1 key = k;
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_deb"}, 32'(key_deb), 32'hf);
        chk({name, "_oh"}, 32'(key_onehot), 32'hf);
        chk({name, "_code"}, 32'(key_code), 32'h0);
        chk({name, "_vld"}, 32'(key_valid), 32'h0);
        chk({name, "_rpt"}, 32'(key_repeat), 32'h0);
        chk({name, "_multi"}, 32'(key_multi), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int t;

        vt[0] = '{4'b0111, 2'd3, 4'b0111};
        vt[1] = '{4'b1011, 2'd2, 4'b1011};
        vt[2] = '{4'b1101, 2'd1, 4'b1101};
        vt[3] = '{4'b1110, 2'd0, 4'b1110};

        // reset with keys idle
        rst_n = 1'b0;
        key   = 4'b1111;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        drive(4'b1111);
        rst_n = 1'b1;
        evq.delete();
        wait_cyc(cyc + 12);
        chk_reset_outs("idle");
        chk("idle_nev", 32'(evq.size()), 32'd0);

        // single presses of each key, with latency checks
        for (int i = 0; i < 4; i++) begin
            evq.delete();
            drive(vt[i].k);
            n = cyc + 1;
            wait_cyc(n + 5);
            chk("lat_deb_early", 32'(key_deb), 32'hf);
            wait_cyc(n + 6);
            chk("lat_deb", 32'(key_deb), 32'(vt[i].k));
            chk("lat_vld_early", 32'(key_valid), 32'h0);
            wait_cyc(n + 7);
            chk("press_vld", 32'(key_valid), 32'h1);
            chk("press_rpt", 32'(key_repeat), 32'h0);
            chk("press_code", 32'(key_code), 32'(vt[i].code));
            chk("press_oh", 32'(key_onehot), 32'(vt[i].oh));
            wait_cyc(n + 8);
            chk("press_vld_1cyc", 32'(key_valid), 32'h0);
            wait_cyc(n + 8);
            drive(4'b1111);
            wait_cyc(cyc + 12);
            chk("rel_deb", 32'(key_deb), 32'hf);
            chk("rel_oh_hold", 32'(key_onehot), 32'(vt[i].oh));
            chk("rel_code_hold", 32'(key_code), 32'(vt[i].code));
            chk("press_nev", 32'(evq.size()), 32'd1);
        end

        // bouncing key[1]: 2-cycle pulses for 12 cycles, then settle low
        evq.delete();
        for (int j = 0; j < 3; j++) begin
            drive(4'b1101);
            drive(4'b1101);
            drive(4'b1111);
            drive(4'b1111);
        end
        drive(4'b1101);
        wait_cyc(cyc + 14);
        chk("bnc_nev", 32'(evq.size()), 32'd1);
        chk("bnc_code", 32'(key_code), 32'd1);
        chk("bnc_oh", 32'(key_onehot), 32'hd);
        chk("bnc_deb", 32'(key_deb), 32'hd);
        drive(4'b1111);
        wait_cyc(cyc + 12);

        // auto-repeat on key[0] held 60 cycles
        evq.delete();
        expq.delete();
        drive(4'b1110);
        n = cyc + 1;
        expq.push_back('{n + 7, 2'd0, 1'b0});
        // release is seen on key_deb at n+66, FSM leaves at edge n+67
        t = n + 27;
        while (t < n + 67) begin
            expq.push_back('{t, 2'd0, 1'b1});
            t += 8;
        end
        wait_cyc(n + 58);
        drive(4'b1111);
        wait_cyc(n + 85);
        chk("rep_nev", 32'(evq.size()), 32'(expq.size()));
        for (int j = 0; j < expq.size(); j++) begin
            if (j < evq.size()) begin
                chk("rep_t", 32'(evq[j].t - n), 32'(expq[j].t - n));
                chk("rep_code", 32'(evq[j].code), 32'(expq[j].code));
                chk("rep_flag", 32'(evq[j].rpt), 32'(expq[j].rpt));
            end
        end

        // key[2] held then key[3] added: lockout
        evq.delete();
        drive(4'b1011);
        n = cyc + 1;
        wait_cyc(n + 12);
        drive(4'b0011);
        wait_cyc(cyc + 20);
        chk("lock_multi", 32'(key_multi), 32'h1);
        chk("lock_deb", 32'(key_deb), 32'h3);
        wait_cyc(cyc + 20);
        chk("lock_nev", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) chk("lock_code", 32'(evq[0].code), 32'd2);
        drive(4'b1111);
        wait_cyc(cyc + 15);
        chk("lock_multi_clr", 32'(key_multi), 32'h0);
        chk("lock_rel_nev", 32'(evq.size()), 32'd1);
        drive(4'b0111);
        wait_cyc(cyc + 12);
        chk("after_lock_nev", 32'(evq.size()), 32'd2);
        if (evq.size() >= 2) chk("after_lock_code", 32'(evq[1].code), 32'd3);
        chk("after_lock_oh", 32'(key_onehot), 32'h7);
        drive(4'b1111);
        wait_cyc(cyc + 12);

        // reset pulsed during REPEAT with key[0] held
        evq.delete();
        drive(4'b1110);
        n = cyc + 1;
        wait_cyc(n + 31);
        chk("pre_rst_nev", 32'(evq.size()), 32'd2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outs("async_rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        evq.delete();
        n = cyc + 1;
        wait_cyc(n + 25);
        chk("post_rst_nev", 32'(evq.size()), 32'd1);
        if (evq.size() >= 1) begin
            chk("post_rst_t", 32'(evq[0].t - n), 32'd7);
            chk("post_rst_code", 32'(evq[0].code), 32'd0);
            chk("post_rst_rpt", 32'(evq[0].rpt), 32'd0);
        end
        drive(4'b1111);
        wait_cyc(cyc + 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
